// File: rtl/packet_serializer.sv
// packet_serializer: transmit side of the inspector wire format.
// Sends one packet per accepted request onto a 1-bit line, MSB first.
// Frame layout: 32-bit preamble, then a BODY_BITS-bit body. The body carries the 16-bit
// port at PORT_POS and the 8-bit session at SESS_POS. Every other body bit is 0.
// After the body the line is forced idle for GAP_BITS cycles.
//
// Ports
//   clk          rising-edge clock, one line bit per cycle
//   rst_n        asynchronous active-low reset
//   pkt_valid    send request, accepted when pkt_ready is high at a rising edge
//   pkt_port     16-bit port, latched on accept
//   pkt_session  8-bit session, latched on accept
//   tx_abort     synchronous abort of the frame in flight (preamble or body only)
//   pkt_ready    high only while idle
//   tx_data      registered serial line, 0 outside a frame
//   tx_busy      high during preamble, body and gap
//   tx_done      one-cycle pulse while the last body bit is on tx_data
//   tx_cnt       count of completed frames, wraps
module packet_serializer #(
  parameter logic [31:0] PREAMBLE  = 32'hA5A5A5A5,
  parameter int unsigned BODY_BITS = 256,
  parameter int unsigned PORT_POS  = 65,
  parameter int unsigned SESS_POS  = 137,
  parameter int unsigned GAP_BITS  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_valid,
  input  logic [15:0] pkt_port,
  input  logic [7:0]  pkt_session,
  input  logic        tx_abort,
  output logic        pkt_ready,
  output logic        tx_data,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [31:0] tx_cnt
);

  // Reject field placements that fall outside the body or overlap each other.
  if (PORT_POS < 1 || SESS_POS < 1 || BODY_BITS > 511 || GAP_BITS > 15 ||
      PORT_POS + 15 > BODY_BITS || SESS_POS + 7 > BODY_BITS ||
      !(PORT_POS + 16 <= SESS_POS || SESS_POS + 8 <= PORT_POS)) begin : g_param_err
    $error("packet_serializer: illegal BODY_BITS/PORT_POS/SESS_POS/GAP_BITS combination");
  end

  typedef enum logic [1:0] {StIdle, StPre, StBody, StGap} state_e;

  localparam logic [8:0] BodyLast = 9'(BODY_BITS);
  localparam logic [3:0] GapLast  = 4'(GAP_BITS);

  state_e      state;
  logic [5:0]  pre_cnt;    // preamble bit index currently on the line, 0 = PREAMBLE[31]
  logic [8:0]  body_cnt;   // body bit number currently on the line, 1..BODY_BITS
  logic [3:0]  gap_cnt;    // gap cycle currently on the line, 1..GAP_BITS
  logic [15:0] port_q;
  logic [7:0]  sess_q;
  logic [31:0] frame_cnt;

  // Value of body bit n (numbered from 1) for the latched fields.
  function automatic logic body_bit(input logic [8:0] n, input logic [15:0] port,
                                    input logic [7:0] sess);
    int unsigned nn;
    int unsigned off;
    nn = 32'(n);
    off = 0;
    body_bit = 1'b0;
    if (nn >= PORT_POS && nn < PORT_POS + 16) begin
      off = nn - PORT_POS;
      body_bit = port[4'(15 - off)];
    end else if (nn >= SESS_POS && nn < SESS_POS + 8) begin
      off = nn - SESS_POS;
      body_bit = sess[3'(7 - off)];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      pre_cnt   <= '0;
      body_cnt  <= '0;
      gap_cnt   <= '0;
      port_q    <= '0;
      sess_q    <= '0;
      tx_data   <= 1'b0;
      tx_done   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      // The frame counts in the cycle its last bit is driven, so a late abort cannot undo it.
      if (tx_done) frame_cnt <= frame_cnt + 32'd1;

      unique case (state)
        StIdle: begin
          tx_data <= 1'b0;
          if (pkt_valid) begin
            state   <= StPre;
            pre_cnt <= '0;
            port_q  <= pkt_port;
            sess_q  <= pkt_session;
            tx_data <= PREAMBLE[31];
          end
        end

        StPre: begin
          if (tx_abort) begin
            tx_data <= 1'b0;
            if (GAP_BITS == 0) begin
              state <= StIdle;
            end else begin
              state   <= StGap;
              gap_cnt <= 4'd1;
            end
          end else if (pre_cnt == 6'd31) begin
            state    <= StBody;
            body_cnt <= 9'd1;
            tx_data  <= body_bit(9'd1, port_q, sess_q);
            tx_done  <= (BodyLast == 9'd1);
          end else begin
            pre_cnt <= pre_cnt + 6'd1;
            tx_data <= PREAMBLE[5'(6'd30 - pre_cnt)];
          end
        end

        StBody: begin
          // Last bit already on the line: the frame is complete even if abort is high now.
          if (body_cnt == BodyLast || tx_abort) begin
            tx_data <= 1'b0;
            if (GAP_BITS == 0) begin
              state <= StIdle;
            end else begin
              state   <= StGap;
              gap_cnt <= 4'd1;
            end
          end else begin
            body_cnt <= body_cnt + 9'd1;
            tx_data  <= body_bit(body_cnt + 9'd1, port_q, sess_q);
            tx_done  <= (body_cnt + 9'd1 == BodyLast);
          end
        end

        StGap: begin
          tx_data <= 1'b0;
          if (gap_cnt == GapLast) begin
            state <= StIdle;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: begin
          state   <= StIdle;
          tx_data <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_ready = (state == StIdle);
  assign tx_busy   = (state != StIdle);
  assign tx_cnt    = frame_cnt;

endmodule

// File: tb/tb_packet_serializer.sv
// Self-checking bench for packet_serializer: table of frame requests, each expanded into an
// expected 288-bit line image pushed to a queue at accept and popped one bit per cycle.
module tb_packet_serializer;

  localparam int unsigned Gap = 2;
  localparam int unsigned FrameBits = 288;
  localparam logic [31:0] Pre = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pkt_valid;
  logic [15:0] pkt_port;
  logic [7:0]  pkt_session;
  logic        tx_abort;
  logic        pkt_ready;
  logic        tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [31:0] tx_cnt;

  packet_serializer #(
    .PREAMBLE (Pre),
    .BODY_BITS(256),
    .PORT_POS (65),
    .SESS_POS (137),
    .GAP_BITS (Gap)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkt_valid  (pkt_valid),
    .pkt_port   (pkt_port),
    .pkt_session(pkt_session),
    .tx_abort   (tx_abort),
    .pkt_ready  (pkt_ready),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_cnt     (tx_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] port;
    logic [7:0]  sess;
    bit          hold;      // keep pkt_valid high through the frame
    bit          scramble;  // change port/session every cycle of the frame
    int          abort_k;   // cycle after accept in which tx_abort is high, 0 = none
    int          rst_k;     // cycle after accept in which reset is pulsed, 0 = none
  } frame_t;

  frame_t      rows[9];
  int          acc[9];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_cnt = '0;
  int          last_acc;
  logic        exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic send(input frame_t f);
    logic [287:0] img;
    logic         eb;
    int           waited;
    pkt_port    = f.port;
    pkt_session = f.sess;
    pkt_valid   = 1'b1;
    waited = 0;
    while (!pkt_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!pkt_ready) begin
      check("accept_timeout", 32'(pkt_ready), 32'd1);
      pkt_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_acc = cyc;
    img = {Pre, 64'd0, f.port, 56'd0, f.sess, 112'd0};
    for (int i = FrameBits - 1; i >= 0; i--) exp_q.push_back(img[i]);

    for (int k = 1; k <= FrameBits; k++) begin
      @(negedge clk);
      tx_abort = 1'b0;
      if (k == 1 && !f.hold) pkt_valid = 1'b0;
      if (f.scramble) begin
        pkt_port    = 16'($urandom);
        pkt_session = 8'($urandom);
      end
      eb = exp_q.pop_front();
      check($sformatf("tx_data[k=%0d]", k), 32'(tx_data), 32'(eb));
      check($sformatf("tx_done[k=%0d]", k), 32'(tx_done), 32'(k == FrameBits));
      check($sformatf("busy/ready[k=%0d]", k), {30'd0, tx_busy, pkt_ready}, 32'b10);

      if (f.rst_k == k) begin
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        exp_q.delete();
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_cnt", tx_cnt, 32'd0);
        check("rst_pkt_ready", 32'(pkt_ready), 32'd1);
        pkt_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end

      if (f.abort_k == k) begin
        tx_abort = 1'b1;
        if (k < FrameBits) begin
          exp_q.delete();
          @(negedge clk);
          tx_abort = 1'b0;
          check("abort_data", 32'(tx_data), 32'd0);
          check("abort_done", 32'(tx_done), 32'd0);
          check("abort_ready", 32'(pkt_ready), 32'd0);
          check("abort_busy", 32'(tx_busy), 32'd1);
          for (int g = 2; g <= Gap; g++) begin
            @(negedge clk);
            check("abort_gap_ready", 32'(pkt_ready), 32'd0);
            check("abort_gap_data", 32'(tx_data), 32'd0);
          end
          @(negedge clk);
          check("abort_ready_back", 32'(pkt_ready), 32'd1);
          check("abort_busy_off", 32'(tx_busy), 32'd0);
          check("abort_cnt_same", tx_cnt, exp_cnt);
          return;
        end
      end
    end

    for (int g = 1; g <= Gap; g++) begin
      @(negedge clk);
      tx_abort = 1'b0;
      check("gap_data", 32'(tx_data), 32'd0);
      check("gap_done", 32'(tx_done), 32'd0);
      check("gap_busy/ready", {30'd0, tx_busy, pkt_ready}, 32'b10);
      if (g == 1) begin
        exp_cnt = exp_cnt + 32'd1;
        check("tx_cnt", tx_cnt, exp_cnt);
      end
    end
    @(negedge clk);
    check("idle_ready", 32'(pkt_ready), 32'd1);
    check("idle_busy", 32'(tx_busy), 32'd0);
    check("idle_data", 32'(tx_data), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{16'd22,     8'd7,     1'b0, 1'b0, 0,   0};
    rows[1] = '{16'd23,     8'h11,    1'b1, 1'b1, 0,   0};
    rows[2] = '{16'd443,    8'h22,    1'b0, 1'b0, 0,   0};
    rows[3] = '{16'hBEEF,   8'hA5,    1'b0, 1'b0, 132, 0};  // abort at body bit 100
    rows[4] = '{16'hC3C3,   8'h3C,    1'b0, 1'b0, 5,   0};  // abort in preamble
    rows[5] = '{16'h5AA5,   8'h81,    1'b0, 1'b0, 288, 0};  // abort on last body bit
    rows[6] = '{16'h1234,   8'h5A,    1'b0, 1'b0, 0,   11}; // reset mid-preamble
    rows[7] = '{16'hFFFF,   8'hFF,    1'b0, 1'b0, 0,   0};
    rows[8] = '{16'h8001,   8'h80,    1'b0, 1'b1, 0,   0};  // field hold under churn

    rst_n = 1'b0;
    pkt_valid = 1'b0;
    pkt_port = '0;
    pkt_session = '0;
    tx_abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_data", 32'(tx_data), 32'd0);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    check("reset_cnt", tx_cnt, 32'd0);
    check("reset_ready", 32'(pkt_ready), 32'd1);

    // Abort while idle must not disturb anything.
    tx_abort = 1'b1;
    repeat (3) @(negedge clk);
    tx_abort = 1'b0;
    check("idle_abort_ready", 32'(pkt_ready), 32'd1);
    check("idle_abort_data", 32'(tx_data), 32'd0);

    for (int r = 0; r < 9; r++) begin
      send(rows[r]);
      acc[r] = last_acc;
      if (r == 2) check("b2b_spacing", 32'(acc[2] - acc[1]), 32'(FrameBits + Gap + 1));
    end

    // Counter wrap.
    @(negedge clk);
    dut.frame_cnt = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    check("wrap_preload", tx_cnt, 32'hFFFF_FFFF);
    send(rows[0]);
    check("wrap_zero", tx_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
